// File: rtl/dataload_pkg.sv
// ---------------------------------------------------------------------------
// dataload_pkg
// Shared definitions for the ping-pong data loader.
//   DEF_DATA_W  : default width of one host bus word
//   load_type_e : selects which packing path a host word is routed to
// ---------------------------------------------------------------------------
package dataload_pkg;

   localparam int DEF_DATA_W = 32;

   typedef enum logic {
      LOAD_WEIGHT = 1'b0,
      LOAD_INPUT  = 1'b1
   } load_type_e;

endpackage

// File: rtl/dataload_pingpong_if.sv
// ---------------------------------------------------------------------------
// dataload_pingpong_if
// Bundles the host word bus and both consumer handshakes of the loader.
//   data_i / load_en_i / load_type_i / load_ready_o : host word stream
//   flush_i                                         : drop partial vectors
//   input_*  / weight_*                             : packed vector outputs
//   err_o                                           : sticky dropped-word flag
// master = host + consumers, slave = loader.
// ---------------------------------------------------------------------------
interface dataload_pingpong_if
   import dataload_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int IN_WORDS = 8,
   parameter int WT_WORDS = 1
);
   logic [DATA_W-1:0]          data_i;
   logic                       load_en_i;
   logic                       load_type_i;
   logic                       load_ready_o;
   logic                       flush_i;
   logic [IN_WORDS*DATA_W-1:0] input_data_o;
   logic                       input_valid_o;
   logic                       input_ready_i;
   logic [WT_WORDS*DATA_W-1:0] weight_data_o;
   logic                       weight_valid_o;
   logic                       weight_ready_i;
   logic                       err_o;

   modport master (
      output data_i, load_en_i, load_type_i, flush_i, input_ready_i, weight_ready_i,
      input  load_ready_o, input_data_o, input_valid_o, weight_data_o, weight_valid_o, err_o
   );

   modport slave (
      input  data_i, load_en_i, load_type_i, flush_i, input_ready_i, weight_ready_i,
      output load_ready_o, input_data_o, input_valid_o, weight_data_o, weight_valid_o, err_o
   );

endinterface

// File: rtl/pingpong_pack_buf.sv
// ---------------------------------------------------------------------------
// pingpong_pack_buf
// Packs WORDS narrow words (LSB first) into a double-buffered wide vector.
//   clk, rst_n : clock, synchronous active-low reset
//   wr_en_i    : word offered on data_i
//   data_i     : word to pack
//   flush_i    : restart the partial vector (offered word is discarded)
//   ready_o    : write bank can take a word
//   data_o     : read bank contents
//   valid_o    : read bank holds a complete vector
//   ready_i    : consumer takes the read bank
// ---------------------------------------------------------------------------
module pingpong_pack_buf #(
   parameter int DATA_W = 32,
   parameter int WORDS  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en_i,
   input  logic [DATA_W-1:0]       data_i,
   input  logic                    flush_i,
   output logic                    ready_o,
   output logic [WORDS*DATA_W-1:0] data_o,
   output logic                    valid_o,
   input  logic                    ready_i
);

   localparam int             CW   = $clog2((WORDS > 2) ? WORDS : 2);
   localparam logic [CW-1:0]  LAST = CW'(WORDS - 1);

   logic [WORDS*DATA_W-1:0] bank_q [2];
   logic [WORDS*DATA_W-1:0] bank_d [2];
   logic [1:0]              full_q, full_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    wr_bank_q, wr_bank_d;
   logic                    rd_bank_q, rd_bank_d;
   logic                    accept, pop;

   // Ready looks only at registered state, so a bank freed by a pop
   // becomes writable one cycle later.
   assign ready_o = rst_n & ~full_q[wr_bank_q];
   assign valid_o = full_q[rd_bank_q];
   assign data_o  = bank_q[rd_bank_q];

   assign accept  = wr_en_i & ready_o & ~flush_i;
   assign pop     = valid_o & ready_i;

   always_comb begin
      bank_d    = bank_q;
      full_d    = full_q;
      cnt_d     = cnt_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;

      // A pop and a fill always touch different banks: the write bank is
      // never full while the read bank is, unless both are.
      if (pop) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end

      if (flush_i) begin
         cnt_d = '0;
      end else if (accept) begin
         for (int k = 0; k < WORDS; k++) begin
            if (cnt_q == CW'(k)) begin
               bank_d[wr_bank_q][k*DATA_W +: DATA_W] = data_i;
            end
         end
         if (cnt_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            cnt_d             = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_q[0] <= '0;
         bank_q[1] <= '0;
         full_q    <= '0;
         cnt_q     <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         full_q    <= full_d;
         cnt_q     <= cnt_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
      end
   end

endmodule

// File: rtl/dataload_pingpong.sv
// ---------------------------------------------------------------------------
// dataload_pingpong
// Front-end loader: routes host words to a double-buffered input-vector
// packer or weight-vector packer and flags any word dropped for lack of room.
//   clk   : clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : host word stream, both vector handshakes, flush and err_o
// ---------------------------------------------------------------------------
module dataload_pingpong
   import dataload_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int IN_WORDS = 8,
   parameter int WT_WORDS = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   dataload_pingpong_if.slave  bus
);

   load_type_e load_type;
   logic       in_wr, wt_wr;
   logic       in_ready, wt_ready;
   logic       err_q, err_d;

   assign load_type = load_type_e'(bus.load_type_i);
   assign in_wr     = bus.load_en_i & (load_type == LOAD_INPUT);
   assign wt_wr     = bus.load_en_i & (load_type == LOAD_WEIGHT);

   pingpong_pack_buf #(.DATA_W(DATA_W), .WORDS(IN_WORDS)) u_input_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en_i (in_wr),
      .data_i  (bus.data_i),
      .flush_i (bus.flush_i),
      .ready_o (in_ready),
      .data_o  (bus.input_data_o),
      .valid_o (bus.input_valid_o),
      .ready_i (bus.input_ready_i)
   );

   pingpong_pack_buf #(.DATA_W(DATA_W), .WORDS(WT_WORDS)) u_weight_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en_i (wt_wr),
      .data_i  (bus.data_i),
      .flush_i (bus.flush_i),
      .ready_o (wt_ready),
      .data_o  (bus.weight_data_o),
      .valid_o (bus.weight_valid_o),
      .ready_i (bus.weight_ready_i)
   );

   assign bus.load_ready_o = (load_type == LOAD_INPUT) ? in_ready : wt_ready;

   // A word discarded by flush is intentional, not an overflow.
   assign err_d = err_q | (bus.load_en_i & ~bus.load_ready_o & ~bus.flush_i);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err_o = err_q;

endmodule
